// File: rtl/spmc_spi_slave.sv
// SPI mode-0 responder for the SpartanMC peripheral bus: 8-bit MSB-first frames,
// single-byte TX/RX holding registers, status flags and an RX interrupt.
//
// state     | meaning
// ST_IDLE   | deselected or disabled; MISO driver off, bit counter held at 0
// ST_ACTIVE | selected and enabled; shifting on SCLK edges, MISO driven
module spmc_spi_slave #(
  parameter logic [9:0] BASE_ADR = 10'h0
) (
  input  logic        clk_peri,
  input  logic        reset,
  input  logic [17:0] do_peri,
  output logic [17:0] di_peri,
  input  logic [9:0]  addr_peri,
  input  logic        access_peri,
  input  logic        wr_peri,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t     state, state_nxt;
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [7:0] tx_hold, rx_hold, shreg;
  logic [2:0] bit_cnt;
  logic       tx_full, rx_full, overrun, underrun, reload_pend;
  logic       enable, rx_ie;

  logic       sel, wr_data, rd_data, wr_status, wr_ctrl;
  logic       do_load, do_shift, do_next, go_idle, rx_done;
  logic       set_under, set_over;
  logic [7:0] load_byte, shift_next;
  logic       unused_do_peri;

  assign unused_do_peri = ^do_peri[17:8];

  // Pin synchronizers; the third sclk/cs stage only feeds edge detection.
  always_ff @(posedge clk_peri or posedge reset) begin
    if (reset) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];

  assign sel       = access_peri & (addr_peri[9:3] == BASE_ADR[9:3]);
  assign wr_data   = sel & wr_peri & (addr_peri[2:0] == 3'd0);
  assign rd_data   = sel & ~wr_peri & (addr_peri[2:0] == 3'd0);
  assign wr_status = sel & wr_peri & (addr_peri[2:0] == 3'd1);
  assign wr_ctrl   = sel & wr_peri & (addr_peri[2:0] == 3'd2);

  always_ff @(posedge clk_peri or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    do_next   = 1'b0;
    go_idle   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall && enable) begin
          state_nxt = ST_ACTIVE;
          do_load   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise || !enable) begin
          state_nxt = ST_IDLE;
          go_idle   = 1'b1;
        end else if (sclk_rise) begin
          do_shift = 1'b1;
        end else if (sclk_fall) begin
          if (reload_pend) do_load = 1'b1;
          else             do_next = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rx_done    = do_shift & (bit_cnt == 3'd7);
  assign shift_next = {shreg[6:0], mosi_q[1]};
  assign load_byte  = tx_full ? tx_hold : 8'hFF;
  // A flag set by hardware beats a software clear in the same cycle.
  assign set_under  = do_load & ~tx_full;
  assign set_over   = rx_done & rx_full & ~rd_data;

  always_ff @(posedge clk_peri or posedge reset) begin
    if (reset) begin
      tx_hold     <= 8'h00;
      rx_hold     <= 8'h00;
      shreg       <= 8'h00;
      bit_cnt     <= 3'd0;
      tx_full     <= 1'b0;
      rx_full     <= 1'b0;
      overrun     <= 1'b0;
      underrun    <= 1'b0;
      reload_pend <= 1'b0;
      enable      <= 1'b0;
      rx_ie       <= 1'b0;
      spi_miso    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= do_peri[0];
        rx_ie  <= do_peri[1];
      end
      if (wr_data) tx_hold <= do_peri[7:0];

      // The load samples the pre-write tx_full/tx_hold; a concurrent write refills.
      if (wr_data)      tx_full <= 1'b1;
      else if (do_load) tx_full <= 1'b0;

      if (set_under)                      underrun <= 1'b1;
      else if (wr_status && do_peri[3])   underrun <= 1'b0;
      if (set_over)                       overrun  <= 1'b1;
      else if (wr_status && do_peri[4])   overrun  <= 1'b0;

      if (rx_done)      rx_full <= 1'b1;
      else if (rd_data) rx_full <= 1'b0;
      if (rx_done) rx_hold <= shift_next;

      if (do_load)       shreg <= load_byte;
      else if (do_shift) shreg <= shift_next;

      if (do_load)      spi_miso <= load_byte[7];
      else if (do_next) spi_miso <= shreg[7];
      else if (go_idle) spi_miso <= 1'b0;

      if (go_idle)       bit_cnt <= 3'd0;
      else if (do_shift) bit_cnt <= bit_cnt + 3'd1;

      if (go_idle)      reload_pend <= 1'b0;
      else if (rx_done) reload_pend <= 1'b1;
      else if (do_load) reload_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_peri or posedge reset) begin
    if (reset) begin
      di_peri <= 18'h0;
    end else if (sel && !wr_peri) begin
      case (addr_peri[2:0])
        3'd0:    di_peri <= {10'b0, rx_hold};
        3'd1:    di_peri <= {13'b0, overrun, underrun, (state == ST_ACTIVE), tx_full, rx_full};
        3'd2:    di_peri <= {16'b0, rx_ie, enable};
        default: di_peri <= 18'h0;
      endcase
    end else begin
      di_peri <= 18'h0;
    end
  end

  assign spi_miso_oe = (state == ST_ACTIVE);
  assign irq         = rx_full & rx_ie;

endmodule
